// File: rtl/fm_bank_sched.sv
// FM ping-pong genome buffer controller: fills two banks from the byte stream and
// drains each full bank in fixed windows, handed round-robin to MinHash consumers.
module fm_bank_sched #(
  parameter int BUFFER_SIZE = 64,
  parameter int WINDOW      = 8,
  parameter int NUM_REQ     = 4,
  localparam int AW   = $clog2(BUFFER_SIZE),
  localparam int IDW  = $clog2(NUM_REQ),
  localparam int NWIN = BUFFER_SIZE / WINDOW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  input  logic [7:0]         i_in_data,
  output logic               o_in_ready,
  output logic               o_wr_en,
  output logic               o_wr_bank,
  output logic [AW-1:0]      o_wr_addr,
  output logic [7:0]         o_wr_data,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_rd_en,
  output logic               o_rd_bank,
  output logic [AW-1:0]      o_rd_addr,
  output logic               o_rsp_valid,
  output logic [IDW-1:0]     o_rsp_id,
  output logic [1:0]         o_bank_full,
  output logic               o_frame_done
);

  localparam int WCW = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int WB  = $clog2(WINDOW);

  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_ISSUE = 1'b1} rd_state_t;

  rd_state_t        r_state;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [AW-1:0]    r_wr_addr;
  logic [WCW-1:0]   r_win_cnt;
  logic [IDW-1:0]   r_ptr;
  logic [1:0]       r_bank_full;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_in_ready;
  logic             w_wr_en;
  logic             w_fill;
  logic             w_issue;
  logic             w_last_win;
  logic             w_release;
  logic             w_found;
  logic [IDW-1:0]   w_pick;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [1:0]       w_set;
  logic [1:0]       w_clr;
  logic [NUM_REQ-1:0] w_onehot;

  assign w_in_ready = ~r_bank_full[r_wr_bank];
  assign w_wr_en    = i_in_valid & w_in_ready;
  assign w_fill     = w_wr_en & (r_wr_addr == AW'(BUFFER_SIZE - 1));
  assign w_issue    = (r_state == RD_ISSUE) & w_found;
  assign w_last_win = (r_win_cnt == WCW'(NWIN - 1));
  assign w_release  = w_issue & w_last_win;
  assign w_ptr_nxt  = (w_pick == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : w_pick + IDW'(1);
  assign w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;

  // A fill and a release always touch different banks, so set and clear never collide.
  assign w_set = {w_fill & r_wr_bank, w_fill & ~r_wr_bank};
  assign w_clr = {w_release & r_rd_bank, w_release & ~r_rd_bank};

  // Round-robin pick: first requester at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = {IDW{1'b0}};
    w_idx   = {IDW{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx   = IDW'((int'(r_ptr) + i) % NUM_REQ);
      w_pick  = (!w_found && i_req[w_idx]) ? w_idx : w_pick;
      w_found = w_found | i_req[w_idx];
    end
  end

  // Write counter and fill bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_addr <= {AW{1'b0}};
      r_wr_bank <= 1'b0;
    end else if (w_wr_en) begin
      if (w_fill) begin
        r_wr_addr <= {AW{1'b0}};
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_addr <= r_wr_addr + AW'(1);
      end
    end
  end

  // Per-bank full flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bank_full <= 2'b00;
    end else begin
      r_bank_full <= (r_bank_full & ~w_clr) | w_set;
    end
  end

  // Read FSM: window counter, drain bank and arbiter pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= RD_IDLE;
      r_rd_bank <= 1'b0;
      r_win_cnt <= {WCW{1'b0}};
      r_ptr     <= {IDW{1'b0}};
    end else begin
      case (r_state)
        RD_IDLE: begin
          r_win_cnt <= {WCW{1'b0}};
          if (r_bank_full[r_rd_bank]) begin
            r_state <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (w_issue) begin
            r_ptr <= w_ptr_nxt;
            if (w_last_win) begin
              r_win_cnt <= {WCW{1'b0}};
              r_rd_bank <= ~r_rd_bank;
              r_state   <= r_bank_full[~r_rd_bank] ? RD_ISSUE : RD_IDLE;
            end else begin
              r_win_cnt <= r_win_cnt + WCW'(1);
            end
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  // Response tag lines up with the buffer's registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= {IDW{1'b0}};
    end else begin
      r_rsp_valid <= w_issue;
      if (w_issue) begin
        r_rsp_id <= w_pick;
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_wr_en      = w_wr_en;
  assign o_wr_bank    = r_wr_bank;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = i_in_data;
  assign o_gnt        = w_issue ? w_onehot : {NUM_REQ{1'b0}};
  assign o_rd_en      = w_issue;
  assign o_rd_bank    = r_rd_bank;
  assign o_rd_addr    = AW'(r_win_cnt) << WB;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_bank_full  = r_bank_full;
  assign o_frame_done = w_release;

endmodule

// File: tb/tb_fm_bank_sched.sv
// Scoreboard bench for fm_bank_sched: expected writes, grants and responses are
// queued as stimulus is driven and popped by a monitor as the DUT produces them.
module tb_fm_bank_sched;

  typedef struct packed {logic bank; logic [5:0] addr; logic [7:0] data;} wr_t;
  typedef struct packed {logic [3:0] gnt; logic bank; logic [5:0] addr; logic fd;} rd_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid;
  logic [7:0]  i_in_data;
  logic        o_in_ready;
  logic        o_wr_en;
  logic        o_wr_bank;
  logic [5:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
  logic [3:0]  i_req;
  logic [3:0]  o_gnt;
  logic        o_rd_en;
  logic        o_rd_bank;
  logic [5:0]  o_rd_addr;
  logic        o_rsp_valid;
  logic [1:0]  o_rsp_id;
  logic [1:0]  o_bank_full;
  logic        o_frame_done;

  int          checks = 0;
  int          failures = 0;
  bit          mon_on = 1'b0;
  logic [31:0] n_sent = 32'd0;

  wr_t         exp_wr[$];
  rd_t         exp_rd[$];
  logic [1:0]  exp_rsp[$];
  wr_t         mw;
  rd_t         mr;
  logic [1:0]  mid;

  fm_bank_sched dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_wr_en(o_wr_en), .o_wr_bank(o_wr_bank), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .i_req(i_req), .o_gnt(o_gnt), .o_rd_en(o_rd_en), .o_rd_bank(o_rd_bank),
    .o_rd_addr(o_rd_addr), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
    .o_bank_full(o_bank_full), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: pops the scoreboard on every write, grant and response.
  always @(negedge clk) begin
    if (mon_on) begin
      if (o_wr_en) begin
        checks++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected: got write bank %0d addr %0d, expected none", o_wr_bank, o_wr_addr);
        end else begin
          mw = exp_wr.pop_front();
          if ({o_wr_bank, o_wr_addr, o_wr_data} !== mw) begin
            failures++;
            $display("FAIL wr_txn: got bank %0d addr %0d data %0h, expected bank %0d addr %0d data %0h",
                     o_wr_bank, o_wr_addr, o_wr_data, mw.bank, mw.addr, mw.data);
          end
        end
      end
      checks++;
      if (o_rd_en) begin
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected: got gnt %b bank %0d addr %0d, expected none", o_gnt, o_rd_bank, o_rd_addr);
        end else begin
          mr = exp_rd.pop_front();
          if ({o_gnt, o_rd_bank, o_rd_addr, o_frame_done} !== mr) begin
            failures++;
            $display("FAIL rd_txn: got gnt %b bank %0d addr %0d fd %0d, expected gnt %b bank %0d addr %0d fd %0d",
                     o_gnt, o_rd_bank, o_rd_addr, o_frame_done, mr.gnt, mr.bank, mr.addr, mr.fd);
          end
        end
      end else if ({o_gnt, o_frame_done} !== 5'b00000) begin
        failures++;
        $display("FAIL idle_gnt: got gnt %b fd %0d, expected 0 without rd_en", o_gnt, o_frame_done);
      end
      if (o_rsp_valid) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got rsp id %0d, expected none", o_rsp_id);
        end else begin
          mid = exp_rsp.pop_front();
          if (o_rsp_id !== mid) begin
            failures++;
            $display("FAIL rsp_id: got %0d, expected %0d", o_rsp_id, mid);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present_byte();
    wr_t e;
    e.bank = n_sent[6];
    e.addr = n_sent[5:0];
    e.data = 8'(n_sent * 37 + 5);
    exp_wr.push_back(e);
    n_sent = n_sent + 32'd1;
    i_in_valid = 1'b1;
    i_in_data  = e.data;
  endtask

  task automatic send_byte();
    bit acc;
    int t;
    present_byte();
    acc = 1'b0;
    t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = o_wr_en;
      tick();
      t++;
    end
    i_in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no acceptance in %0d cycles, expected acceptance", t);
    end
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) send_byte();
  endtask

  task automatic push_rd(input logic [1:0] id, input logic bank, input int win, input logic fd);
    rd_t e;
    e.gnt  = 4'b0001 << id;
    e.bank = bank;
    e.addr = 6'(win * 8);
    e.fd   = fd;
    exp_rd.push_back(e);
    exp_rsp.push_back(id);
  endtask

  task automatic push_bank(input logic bank);
    for (int w = 0; w < 8; w++) push_rd(2'd0, bank, w, (w == 7) ? 1'b1 : 1'b0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_rd.size() + exp_rsp.size() + exp_wr.size()) != 0 && t < 100) begin
      tick();
      t++;
    end
  endtask

  task automatic apply_reset();
    mon_on = 1'b0;
    rst_n = 1'b0;
    i_req = 4'b0000;
    i_in_valid = 1'b0;
    tick();
    tick();
    exp_wr.delete();
    exp_rd.delete();
    exp_rsp.delete();
    n_sent = 32'd0;
    rst_n = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_reset();
    mon_on = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({o_in_ready, o_gnt, o_rd_en, o_rsp_valid, o_rsp_id, o_frame_done, o_bank_full} !== 12'b1_0000_0_0_00_0_00) begin
      failures++;
      $display("FAIL reset_outputs: got rdy %0d gnt %b rd %0d rv %0d rid %0d fd %0d full %b, expected 1 0000 0 0 0 0 00",
               o_in_ready, o_gnt, o_rd_en, o_rsp_valid, o_rsp_id, o_frame_done, o_bank_full);
    end
    checks++;
    if ({o_wr_bank, o_wr_addr, o_rd_bank, o_rd_addr} !== 14'd0) begin
      failures++;
      $display("FAIL reset_addrs: got wb %0d wa %0d rb %0d ra %0d, expected all 0",
               o_wr_bank, o_wr_addr, o_rd_bank, o_rd_addr);
    end
    tick();
    rst_n = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_basic();
    apply_reset();
    i_req = 4'b0001;
    push_bank(1'b0);
    send_n(64);
    @(negedge clk);
    checks++;
    if (o_bank_full !== 2'b01 || o_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL basic_full: got full %b rd_en %0d, expected 01 0", o_bank_full, o_rd_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (o_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency: got rd_en %0d two cycles after last write, expected 1", o_rd_en);
    end
    tick();
    wait_drain();
    checks++;
    if ((exp_rd.size() + exp_rsp.size()) != 0 || o_bank_full !== 2'b00) begin
      failures++;
      $display("FAIL basic_drain: got %0d pending full %b, expected 0 pending full 00",
               exp_rd.size() + exp_rsp.size(), o_bank_full);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    send_n(64);
    for (int k = 0; k < 8; k++) push_rd(2'(k % 4), 1'b0, k, (k == 7) ? 1'b1 : 1'b0);
    i_req = 4'b1111;
    wait_drain();
    i_req = 4'b0000;
    checks++;
    if ((exp_rd.size() + exp_rsp.size()) != 0 || o_bank_full !== 2'b00) begin
      failures++;
      $display("FAIL rr_drain: got %0d pending full %b, expected 0 pending full 00",
               exp_rd.size() + exp_rsp.size(), o_bank_full);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    for (int i = 0; i < 64; i++) begin
      send_byte();
      @(negedge clk);
      checks++;
      if (o_wr_en !== 1'b0 || o_wr_addr !== 6'(n_sent % 64)) begin
        failures++;
        $display("FAIL gap_hold: got wr_en %0d addr %0d, expected 0 %0d", o_wr_en, o_wr_addr, n_sent % 64);
      end
      tick();
    end
    push_bank(1'b0);
    i_req = 4'b0001;
    tick();
    tick();
    tick();
    i_req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_rd_en !== 1'b0 || o_rd_addr !== 6'd24) begin
        failures++;
        $display("FAIL req_gap_hold: got rd_en %0d addr %0d, expected 0 24", o_rd_en, o_rd_addr);
      end
      tick();
    end
    i_req = 4'b0001;
    wait_drain();
    checks++;
    if ((exp_rd.size() + exp_rsp.size()) != 0 || o_bank_full !== 2'b00) begin
      failures++;
      $display("FAIL gap_drain: got %0d pending full %b, expected 0 pending full 00",
               exp_rd.size() + exp_rsp.size(), o_bank_full);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    bit prev_fd;
    apply_reset();
    send_n(128);
    present_byte();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_in_ready !== 1'b0 || o_bank_full !== 2'b11) begin
        failures++;
        $display("FAIL bp_stall: got ready %0d full %b, expected 0 11", o_in_ready, o_bank_full);
      end
      tick();
    end
    push_bank(1'b0);
    push_bank(1'b1);
    i_req = 4'b0001;
    got = 1'b0;
    prev_fd = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (o_wr_en) begin
        got = 1'b1;
        checks++;
        if (!prev_fd) begin
          failures++;
          $display("FAIL bp_resume: got write cycle without prior frame_done, expected write right after release");
        end
      end
      prev_fd = o_frame_done;
      tick();
    end
    i_in_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL bp_timeout: got no write of byte 129, expected write after release");
    end
    send_byte();
    wait_drain();
    i_req = 4'b0000;
    checks++;
    if ((exp_rd.size() + exp_rsp.size() + exp_wr.size()) != 0 || o_bank_full !== 2'b00) begin
      failures++;
      $display("FAIL bp_drain: got %0d pending full %b, expected 0 pending full 00",
               exp_rd.size() + exp_rsp.size() + exp_wr.size(), o_bank_full);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    send_n(64);
    send_n(56);
    push_bank(1'b0);
    push_bank(1'b1);
    i_req = 4'b0001;
    send_n(8);
    present_byte();
    @(negedge clk);
    checks++;
    if (o_bank_full !== 2'b10 || o_in_ready !== 1'b1 || o_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL sim_next: got full %b ready %0d rd_en %0d, expected 10 1 0", o_bank_full, o_in_ready, o_rd_en);
    end
    tick();
    i_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_rd_en !== 1'b1 || o_rd_bank !== 1'b1 || o_rd_addr !== 6'd0) begin
      failures++;
      $display("FAIL sim_bank1: got rd_en %0d bank %0d addr %0d, expected 1 1 0", o_rd_en, o_rd_bank, o_rd_addr);
    end
    tick();
    wait_drain();
    i_req = 4'b0000;
    checks++;
    if ((exp_rd.size() + exp_rsp.size() + exp_wr.size()) != 0 || o_bank_full !== 2'b00) begin
      failures++;
      $display("FAIL sim_drain: got %0d pending full %b, expected 0 pending full 00",
               exp_rd.size() + exp_rsp.size() + exp_wr.size(), o_bank_full);
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    send_n(64);
    send_n(10);
    for (int k = 0; k < 3; k++) push_rd(2'(k), 1'b0, k, 1'b0);
    i_req = 4'b1111;
    tick();
    tick();
    tick();
    mon_on = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({o_bank_full, o_rsp_valid, o_gnt, o_in_ready, o_wr_bank, o_wr_addr} !== 15'b00_0_0000_1_0_000000) begin
      failures++;
      $display("FAIL mid_reset: got full %b rv %0d gnt %b rdy %0d wb %0d wa %0d, expected 00 0 0000 1 0 0",
               o_bank_full, o_rsp_valid, o_gnt, o_in_ready, o_wr_bank, o_wr_addr);
    end
    tick();
    exp_wr.delete();
    exp_rd.delete();
    exp_rsp.delete();
    n_sent = 32'd0;
    rst_n = 1'b1;
    i_req = 4'b0001;
    mon_on = 1'b1;
    push_bank(1'b0);
    send_n(64);
    wait_drain();
    i_req = 4'b0000;
    checks++;
    if ((exp_rd.size() + exp_rsp.size()) != 0 || o_bank_full !== 2'b00) begin
      failures++;
      $display("FAIL mid_refill: got %0d pending full %b, expected 0 pending full 00",
               exp_rd.size() + exp_rsp.size(), o_bank_full);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_in_valid = 1'b0;
    i_in_data = 8'h00;
    i_req = 4'b0000;
    test_reset();
    test_basic();
    test_round_robin();
    test_gaps();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_drain();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
